// File: rtl/dcache_pkg.sv
// Shared widths, address field positions and FSM encoding for the direct-mapped
// write-back data cache.
package dcache_pkg;
    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 128;
    localparam int MEM_ADDR_W      = 28;
    localparam int PROC_ADDR_W     = 30;
    localparam int WORDS_PER_BLOCK = BLOCK_W / WORD_W;

    // Word-in-block offset occupies the low bits of the word address
    localparam int OFFSET_LSB = 0;
    localparam int OFFSET_W   = 2;
    localparam int INDEX_LSB  = OFFSET_LSB + OFFSET_W;

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] WRITEBACK   = 2'd1;
    localparam logic [1:0] ALLOCATE    = 2'd2;
    localparam logic [1:0] REFILL_DONE = 2'd3;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [BLOCK_W-1:0] block_t;
endpackage

// File: rtl/dcache_line_store.sv
// Per-line valid/dirty/tag/data storage with asynchronous read of one index and
// a single-index write of either one word (store hit) or a whole block (refill).
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int NUM_BLOCKS = 8,
    parameter int INDEX_W    = 3,
    parameter int TAG_W      = MEM_ADDR_W - INDEX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  rd_idx_i,
    output logic                rd_valid_o,
    output logic                rd_dirty_o,
    output logic [TAG_W-1:0]    rd_tag_o,
    output block_t              rd_data_o,
    input  logic [INDEX_W-1:0]  wr_idx_i,
    input  logic                wr_word_en_i,
    input  logic [OFFSET_W-1:0] wr_word_sel_i,
    input  word_t               wr_word_data_i,
    input  logic                wr_block_en_i,
    input  logic [TAG_W-1:0]    wr_tag_i,
    input  block_t              wr_block_data_i
);
    logic             valid_q [NUM_BLOCKS];
    logic             dirty_q [NUM_BLOCKS];
    logic [TAG_W-1:0] tag_q   [NUM_BLOCKS];
    block_t           data_q  [NUM_BLOCKS];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BLOCKS; gi++) begin : g_line
            logic line_sel;
            assign line_sel = (wr_idx_i == INDEX_W'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q[gi] <= 1'b0;
                    dirty_q[gi] <= 1'b0;
                end else if (line_sel && wr_block_en_i) begin
                    valid_q[gi] <= 1'b1;
                    dirty_q[gi] <= 1'b0;
                end else if (line_sel && wr_word_en_i) begin
                    dirty_q[gi] <= 1'b1;
                end
            end

            // Tag and data need no reset; a reset edge must still not update them
            always_ff @(posedge clk) begin
                if (!rst && line_sel && wr_block_en_i) begin
                    tag_q[gi]  <= wr_tag_i;
                    data_q[gi] <= wr_block_data_i;
                end else if (!rst && line_sel && wr_word_en_i) begin
                    data_q[gi][int'(wr_word_sel_i)*WORD_W +: WORD_W] <= wr_word_data_i;
                end
            end
        end
    endgenerate
endmodule

// File: rtl/dcache_wb_direct.sv
// Direct-mapped write-back write-allocate L1 data cache with miss FSM.
// Optional DCACHE_STATS_EN adds hit_cnt / miss_cnt outputs.
module dcache_wb_direct
    import dcache_pkg::*;
#(
    parameter int NUM_BLOCKS = 8,
    parameter int INDEX_W    = 3,
    parameter int TAG_W      = MEM_ADDR_W - INDEX_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   proc_read,
    input  logic                   proc_write,
    input  logic [PROC_ADDR_W-1:0] proc_addr,
    input  logic [WORD_W-1:0]      proc_wdata,
    output logic                   proc_stall,
    output logic [WORD_W-1:0]      proc_rdata,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [MEM_ADDR_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0]     mem_wdata,
    input  logic [BLOCK_W-1:0]     mem_rdata,
    input  logic                   mem_ready
`ifdef DCACHE_STATS_EN
   ,output logic [31:0]            hit_cnt,
    output logic [31:0]            miss_cnt
`endif
);
    logic [OFFSET_W-1:0] req_word;
    logic [INDEX_W-1:0]  req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic                req;

    assign req_word = proc_addr[INDEX_LSB-1:OFFSET_LSB];
    assign req_idx  = proc_addr[INDEX_LSB+INDEX_W-1:INDEX_LSB];
    assign req_tag  = proc_addr[PROC_ADDR_W-1:INDEX_LSB+INDEX_W];
    assign req      = proc_read | proc_write;

    logic             line_valid;
    logic             line_dirty;
    logic [TAG_W-1:0] line_tag;
    block_t           line_data;
    word_t            line_words [WORDS_PER_BLOCK];
    logic             hit;
    logic             wr_word_en;
    logic             wr_block_en;

    dcache_line_store #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .INDEX_W    (INDEX_W),
        .TAG_W      (TAG_W)
    ) u_store (
        .clk             (clk),
        .rst             (rst),
        .rd_idx_i        (req_idx),
        .rd_valid_o      (line_valid),
        .rd_dirty_o      (line_dirty),
        .rd_tag_o        (line_tag),
        .rd_data_o       (line_data),
        .wr_idx_i        (req_idx),
        .wr_word_en_i    (wr_word_en),
        .wr_word_sel_i   (req_word),
        .wr_word_data_i  (proc_wdata),
        .wr_block_en_i   (wr_block_en),
        .wr_tag_i        (req_tag),
        .wr_block_data_i (mem_rdata)
    );

    genvar gi;
    generate
        for (gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_word
            assign line_words[gi] = line_data[gi*WORD_W +: WORD_W];
        end
    endgenerate

    assign hit = line_valid && (line_tag == req_tag);

    logic [1:0]            state_q, state_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    block_t                mem_wdata_q, mem_wdata_d;

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        proc_stall  = 1'b0;
        proc_rdata  = '0;
        wr_word_en  = 1'b0;
        wr_block_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && hit) begin
                    // A simultaneous read+write is treated as a write
                    if (proc_write) wr_word_en = 1'b1;
                    else            proc_rdata = line_words[req_word];
                end else if (req) begin
                    proc_stall = 1'b1;
                    if (line_valid && line_dirty) begin
                        mem_write_d = 1'b1;
                        mem_addr_d  = {line_tag, req_idx};
                        mem_wdata_d = line_data;
                        state_d     = WRITEBACK;
                    end else begin
                        mem_read_d = 1'b1;
                        mem_addr_d = {req_tag, req_idx};
                        state_d    = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                proc_stall = 1'b1;
                if (mem_ready) begin
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = {req_tag, req_idx};
                    state_d     = ALLOCATE;
                end
            end
            ALLOCATE: begin
                proc_stall = 1'b1;
                if (mem_ready) begin
                    mem_read_d  = 1'b0;
                    wr_block_en = 1'b1;
                    state_d     = REFILL_DONE;
                end
            end
            default: begin
                // One dead cycle so a mem_ready held high is not seen twice
                proc_stall = 1'b1;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == IDLE && req) begin
            if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
            else     miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_dcache_wb_direct.sv
// Directed bench for dcache_wb_direct with a fixed-latency block memory model.
// Compile with +define+DCACHE_STATS_EN to also exercise the counters.
module tb_dcache_wb_direct;
    localparam int L = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         proc_read, proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    dcache_wb_direct dut (
        .clk        (clk),
        .rst        (rst),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
`ifdef DCACHE_STATS_EN
       ,.hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Unwritten blocks hold word address based data: word w of block a = B000_0000 + 4a + w
    function automatic logic [127:0] pat(input logic [27:0] a);
        logic [127:0] b;
        for (int w = 0; w < 4; w++) b[w*32 +: 32] = 32'hB000_0000 + {2'b00, a, 2'b00} + 32'(w);
        return b;
    endfunction

    logic [127:0] mem_blk [logic [27:0]];

    // Memory answers L cycles after a request appears; ready lasts one cycle
    initial begin
        int cnt;
        cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                mem_ready = 1'b0;
                cnt = 0;
            end
            if (mem_read === 1'b1 || mem_write === 1'b1) begin
                cnt++;
                if (cnt == L) begin
                    mem_ready = 1'b1;
                    if (mem_write) mem_blk[mem_addr] = mem_wdata;
                    else mem_rdata = mem_blk.exists(mem_addr) ? mem_blk[mem_addr] : pat(mem_addr);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    int           s_stalls;
    logic [31:0]  s_rdata;
    logic         s_rd_seen, s_wb_seen;
    logic [27:0]  s_rd_addr, s_wb_addr;
    logic [127:0] s_wb_data;

    // Called #1 after a rising edge; holds the request until stall drops
    task automatic access(input logic wr, input logic [29:0] addr, input logic [31:0] wdata);
        logic done;
        done = 1'b0;
        s_stalls = 0; s_rdata = '0;
        s_rd_seen = 1'b0; s_wb_seen = 1'b0;
        s_rd_addr = '0; s_wb_addr = '0; s_wb_data = '0;
        proc_read = !wr; proc_write = wr; proc_addr = addr; proc_wdata = wdata;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (mem_write && !s_wb_seen) begin
                s_wb_seen = 1'b1; s_wb_addr = mem_addr; s_wb_data = mem_wdata;
            end
            if (mem_read && !s_rd_seen) begin
                s_rd_seen = 1'b1; s_rd_addr = mem_addr;
            end
            if (!proc_stall) begin
                s_rdata = proc_rdata;
                done = 1'b1;
            end else begin
                s_stalls++;
            end
        end
        if (!done) check("access_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        proc_read = 1'b0; proc_write = 1'b0;
        $display("%s addr=%08h stalls=%0d rdata=%08h wb=%0b/%07h rd=%0b/%07h",
                 wr ? "WR" : "RD", addr, s_stalls, s_rdata, s_wb_seen, s_wb_addr, s_rd_seen, s_rd_addr);
    endtask

    initial begin
        rst = 1'b1;
        proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0; proc_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", proc_stall, 1'b0);
        check("rst_rdata", proc_rdata, 32'h0);
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mem_addr", mem_addr, 28'h0);
        check("rst_mem_wdata", mem_wdata, 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Cold read miss, clean: L+2 stall cycles
        access(1'b0, 30'h10, 32'h0);
        check("miss_rd_stalls", s_stalls, 5);
        check("miss_rd_addr", s_rd_addr, 28'h4);
        check("miss_no_wb", s_wb_seen, 1'b0);
        check("miss_rdata", s_rdata, 32'hB000_0010);

        access(1'b0, 30'h10, 32'h0);
        check("hit_rd_stalls", s_stalls, 0);
        check("hit_rd_w0", s_rdata, 32'hB000_0010);
        access(1'b0, 30'h13, 32'h0);
        check("hit_rd_w3", s_rdata, 32'hB000_0013);

        access(1'b1, 30'h11, 32'hDEAD_BEEF);
        check("hit_wr_stalls", s_stalls, 0);
        access(1'b0, 30'h11, 32'h0);
        check("hit_rd_after_wr", s_rdata, 32'hDEAD_BEEF);

        // Same index, new tag, dirty victim: 2L+2 stall cycles
        access(1'b0, 30'h111, 32'h0);
        check("dirty_stalls", s_stalls, 8);
        check("dirty_wb_seen", s_wb_seen, 1'b1);
        check("dirty_wb_addr", s_wb_addr, 28'h4);
        check("dirty_wb_w1", s_wb_data[63:32], 32'hDEAD_BEEF);
        check("dirty_wb_block", s_wb_data, {32'hB000_0013, 32'hB000_0012, 32'hDEAD_BEEF, 32'hB000_0010});
        check("dirty_rd_addr", s_rd_addr, 28'h44);
        check("dirty_rdata", s_rdata, 32'hB000_0111);

        // Write miss allocates, then the write lands; eviction carries it back
        access(1'b1, 30'h20, 32'h1234_5678);
        check("wrmiss_stalls", s_stalls, 5);
        check("wrmiss_rd_addr", s_rd_addr, 28'h8);
        access(1'b0, 30'h20, 32'h0);
        check("wrmiss_readback", s_rdata, 32'h1234_5678);
        access(1'b0, 30'h0, 32'h0);
        check("evict_stalls", s_stalls, 8);
        check("evict_wb_addr", s_wb_addr, 28'h8);
        check("evict_wb_block", s_wb_data, {32'hB000_0023, 32'hB000_0022, 32'hB000_0021, 32'h1234_5678});
        check("evict_rdata", s_rdata, 32'hB000_0000);
        access(1'b0, 30'h20, 32'h0);
        check("refetch_stalls", s_stalls, 5);
        check("refetch_rdata", s_rdata, 32'h1234_5678);

        // Reset in the middle of a refill drops the request
        proc_read = 1'b1; proc_addr = 30'h48;
        @(negedge clk);
        check("pre_rst_stall", proc_stall, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("alloc_mem_read", mem_read, 1'b1);
        check("alloc_mem_addr", mem_addr, 28'h12);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; proc_read = 1'b0;
        @(negedge clk);
        check("post_rst_mem_read", mem_read, 1'b0);
        check("post_rst_stall", proc_stall, 1'b0);
        @(posedge clk); #1;
        access(1'b0, 30'h48, 32'h0);
        check("rerd_stalls", s_stalls, 5);
        check("rerd_rd_addr", s_rd_addr, 28'h12);
        check("rerd_rdata", s_rdata, 32'hB000_0048);
        access(1'b0, 30'h10, 32'h0);
        check("post_rst_miss_stalls", s_stalls, 5);
        check("post_rst_miss_rdata", s_rdata, 32'hB000_0010);
        access(1'b0, 30'h49, 32'h0);
        check("post_rst_hit_stalls", s_stalls, 0);
        check("post_rst_hit_rdata", s_rdata, 32'hB000_0049);
`ifdef DCACHE_STATS_EN
        // Two misses (each then hits once) plus one plain hit
        check("hit_cnt", hit_cnt, 32'd3);
        check("miss_cnt", miss_cnt, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_wb_direct.md
Name: dcache_wb_direct

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the pipeline's memory stage (DCACHE_* signals) and the external 128-bit block memory.
- Hits complete in the request cycle with stall low.
- Misses raise stall, write back a dirty victim if needed, then fetch the new block and release the pipeline.
- The instruction side instantiates the same block with the write port tied off.

Parameters:
NUM_BLOCKS, 8, number of cache lines; power of two.
INDEX_W, 3, log2(NUM_BLOCKS).
TAG_W, 25, 28 - INDEX_W; tag bits of the block address.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
proc_read  in  1  load request; held by the pipeline while proc_stall=1
proc_write  in  1  store request; held while proc_stall=1
proc_addr  in  30  word address: [1:0] word-in-block, [INDEX_W+1:2] index, [29:INDEX_W+2] tag
proc_wdata  in  32  store data
proc_stall  out  1  combinational; 1 while request not serviceable this cycle
proc_rdata  out  32  combinational load data; valid when proc_read=1 and proc_stall=0
mem_read  out  1  registered block-read request
mem_write  out  1  registered block-write request
mem_addr  out  28  registered block address {tag,index}
mem_wdata  out  128  registered victim block; word0 in [31:0]
mem_rdata  in  128  fetched block, sampled when mem_ready=1
mem_ready  in  1  memory completion, asserted one or more cycles

Behaviour:
- Per line storage: valid, dirty, tag[TAG_W], data[128].
- hit = valid[idx] & (tag[idx]==proc_addr tag).
- Reset: all valid and dirty bits cleared; state IDLE; mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- proc_stall and proc_rdata follow from state and hit. With no request, proc_stall=0 and proc_rdata=0.
- Both proc_read and proc_write high: illegal. The cache treats it as a write.
- FSM states: IDLE, WRITEBACK, ALLOCATE, REFILL_DONE.
- IDLE, no request: stay; proc_stall=0.
- IDLE, read hit: proc_rdata = selected word same cycle; proc_stall=0; stay.
- IDLE, write hit: selected word <= proc_wdata at edge, dirty<=1; proc_stall=0; stay.
- IDLE, miss, victim valid & dirty: proc_stall=1. At the edge, mem_write<=1, mem_addr<={victim tag,idx}, mem_wdata<=victim data; go WRITEBACK.
- IDLE, miss, clean or invalid victim: proc_stall=1. At the edge, mem_read<=1, mem_addr<={req tag,idx}; go ALLOCATE.
- WRITEBACK: proc_stall=1; hold outputs until mem_ready=1. At that edge, mem_write<=0, mem_read<=1, mem_addr<={req tag,idx}; go ALLOCATE.
- ALLOCATE: proc_stall=1; hold until mem_ready=1. At that edge, mem_read<=0, data<=mem_rdata, tag<=req tag, valid<=1, dirty<=0; go REFILL_DONE.
- REFILL_DONE: proc_stall=1 for one cycle, which absorbs a multi-cycle mem_ready; go IDLE. The held request then hits.
- Write miss cost: refill, REFILL_DONE, then the write hit in IDLE sets dirty.
- Miss latency with memory latency L cycles (ready L cycles after request): clean miss stalls L+2 cycles; dirty miss stalls 2L+2 cycles.
- Memory requests never change while waiting for mem_ready.
- mem_read and mem_write are never high together.
- rst asserted in any state: returns to IDLE next edge. An outstanding memory request is dropped and no line update occurs.
- Index wrap: addresses differing only in tag alias the same line; eviction is by index only.

Optional Feature:
- Macro DCACHE_STATS_EN adds outputs hit_cnt[31:0] and miss_cnt[31:0], both reset to 0.
- hit_cnt increments once per request accepted in IDLE with hit (proc_stall=0).
- miss_cnt increments once per IDLE→WRITEBACK or IDLE→ALLOCATE transition.
- Counters wrap at 2^32.
- Without the macro: ports absent; no counter logic.

Decomposition:
- Package dcache_pkg holds:
  - widths: WORD_W=32, BLOCK_W=128, MEM_ADDR_W=28, PROC_ADDR_W=30
  - state encoding: IDLE=2'd0, WRITEBACK=2'd1, ALLOCATE=2'd2, REFILL_DONE=2'd3
  - word-offset field positions
- One natural sub-module: dcache_line_store. It contains the valid/dirty/tag/data arrays, async read of one index, and single-index write with word or block enable.
- The FSM and hit logic stay in dcache_wb_direct.

Test Plan:
- Reset, then read 0x0000_0010 with memory block = {W3..W0}: mem_read=1, mem_addr=0x0000004. After ready (L=3), stall drops after 5 stall cycles total and proc_rdata=W0. Repeat read: stall=0 same cycle.
- Write 0x0000_0011 data 0xDEADBEEF on a resident line: stall=0. Next read of 0x0000_0011 returns 0xDEADBEEF. Line dirty.
- Read 0x0000_0111 (same index 4, new tag) on that dirty line: mem_write first, mem_addr=0x0000004, mem_wdata[63:32]=0xDEADBEEF. Then mem_read with mem_addr=0x0000044; stall 2L+2 cycles.
- Write miss to a clean line: refill, then the word is written. Later eviction writes the modified block back.
- rst pulsed during ALLOCATE: mem_read=0 next cycle. Re-read of the same address misses again with a full refill.
- DCACHE_STATS_EN build: 3 hits + 2 misses → hit_cnt=3, miss_cnt=2.
